// File: rtl/unique_dispatcher.sv
// Group dispatcher: buffers packed groups and emits one beat per unique
// non-zero value, with the positions it occupies, lowest unique first.
module unique_dispatcher #(
    parameter int GROUP_SIZE             = 4,
    parameter int DATA_WIDTH             = 8,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   configure,
    input  logic [LOG_MAX_ITERS-1:0]               num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0]      num_reads_per_iter,
    input  logic [GROUP_SIZE*DATA_WIDTH+GROUP_SIZE*GROUP_SIZE+GROUP_SIZE-1:0] data_in,
    input  logic                                   valid_in,
    output logic                                   avail_out,
    output logic [DATA_WIDTH+GROUP_SIZE:0]         data_out,
    output logic                                   valid_out,
    input  logic                                   avail_in,
    output logic                                   done,
    output logic                                   overflow_err
);

    localparam int GS = GROUP_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int LI = LOG_MAX_ITERS;
    localparam int LR = LOG_MAX_READS_PER_ITER;
    localparam int PW = GS*DW + GS*GS + GS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0][PW-1:0]  mem_q, mem_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [GS-1:0]       pending_q, pending_d;
    logic [LI-1:0]       iters_q, iters_d;
    logic [LR-1:0]       reads_q, reads_d;
    logic [LR-1:0]       nreads_q, nreads_d;
    logic                ovf_q, ovf_d;

    logic [PW-1:0]       head;
    logic [GS*DW-1:0]    vals;
    logic [GS*GS-1:0]    rep;
    logic [GS-1:0]       zero;
    logic [GS-1:0]       diag;
    logic [GS-1:0]       sel_oh;
    logic [GS-1:0]       rest;
    logic [GS-1:0]       pos;
    logic [DW-1:0]       val;
    logic                enabled;
    logic                wr_ok;
    logic                beat;
    logic                pop;

    always_comb begin
        head = mem_q[rd_ptr_q];
        vals = head[GS*DW-1:0];
        rep  = head[GS*DW +: GS*GS];
        zero = head[GS*DW+GS*GS +: GS];
        diag = '0;
        for (int i = 0; i < GS; i++) begin
            diag[i] = rep[i*GS+i];
        end
        // isolate lowest pending unique
        sel_oh = pending_q & (~pending_q + GS'(1));
        rest   = pending_q & ~sel_oh;
        pos    = '0;
        val    = '0;
        for (int i = 0; i < GS; i++) begin
            if (sel_oh[i]) begin
                pos = rep[i*GS +: GS];
                val = vals[i*DW +: DW];
            end
        end
    end

    always_comb begin
        enabled = (state_q == S_LOAD) || (state_q == S_EMIT);
        wr_ok   = valid_in && enabled && (cnt_q != 2'd2) && !configure;
        beat    = (state_q == S_EMIT) && avail_in;
        pop     = beat && (rest == '0);

        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        iters_d   = iters_q;
        reads_d   = reads_q;
        nreads_d  = nreads_q;
        ovf_d     = ovf_q;

        if (configure) begin
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            cnt_d     = 2'd0;
            pending_d = '0;
            ovf_d     = 1'b0;
            iters_d   = num_iters;
            reads_d   = num_reads_per_iter;
            nreads_d  = num_reads_per_iter;
            if (num_iters != '0 && num_reads_per_iter != '0) begin
                state_d = S_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end else begin
            if (valid_in && !wr_ok) begin
                ovf_d = 1'b1;
            end
            if (wr_ok) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, wr_ok} - {1'b0, pop};

            case (state_q)
                S_LOAD: begin
                    if (cnt_q != 2'd0) begin
                        pending_d = diag & ~zero;
                        state_d   = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (beat) begin
                        pending_d = rest;
                    end
                    if (pop) begin
                        state_d = S_LOAD;
                        if (reads_q == LR'(1)) begin
                            reads_d = nreads_q;
                            iters_d = iters_q - LI'(1);
                            if (iters_q == LI'(1)) begin
                                state_d = S_DONE;
                            end
                        end else begin
                            reads_d = reads_q - LR'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mem_q     <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            pending_q <= '0;
            iters_q   <= '0;
            reads_q   <= '0;
            nreads_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            iters_q   <= iters_d;
            reads_q   <= reads_d;
            nreads_q  <= nreads_d;
            ovf_q     <= ovf_d;
        end
    end

    // an all-zero group leaves pending empty, giving the single zero beat
    always_comb begin
        avail_out    = enabled && (cnt_q == 2'd0);
        valid_out    = beat;
        data_out     = beat ? {rest == '0, pos, val} : '0;
        done         = (state_q == S_DONE);
        overflow_err = ovf_q;
    end

endmodule
